check_case_scheduler: RTL

- Sequences a self-checking bench through up to NUM_CASES independent check cases, one at a time, in ascending index order.
- Each case is a requester that gets a one-cycle launch pulse, then returns a done/pass pair. The scheduler enforces a per-case timeout.
- Accumulates a failure mask and a timeout mask, and drives the single PASSED/FAILED verdict that the top-level bench prints.
- Sits between the bench top and the per-case check blocks: name-collision cases, generate-block cases, instance cases.

---
 rtl/check_case_scheduler_if.sv | 28 ++
 rtl/check_case_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/check_case_scheduler_if.sv
// Handshake bundle between the bench top (master) and the check-case scheduler (slave).
// The launch/done/pass vectors carry one bit per case slot.
interface check_case_scheduler_if #(
  parameter int NUM_CASES = 8,
  parameter int IDX_W     = 5
);
  logic                 start;
  logic [NUM_CASES-1:0] enable_mask;
  logic [NUM_CASES-1:0] case_start;
  logic [NUM_CASES-1:0] case_done;
  logic [NUM_CASES-1:0] case_pass;
  logic                 busy;
  logic [IDX_W-1:0]     cur_case;
  logic [NUM_CASES-1:0] fail_mask;
  logic [NUM_CASES-1:0] timeout_mask;
  logic                 done;
  logic                 passed;

  modport master (
    output start, enable_mask, case_done, case_pass,
    input  case_start, busy, cur_case, fail_mask, timeout_mask, done, passed
  );

  modport slave (
    input  start, enable_mask, case_done, case_pass,
    output case_start, busy, cur_case, fail_mask, timeout_mask, done, passed
  );
endinterface

// File: rtl/check_case_scheduler.sv
// Runs enabled check cases one at a time in ascending order, enforcing a per-case
// timeout and accumulating fail/timeout masks into a single PASSED/FAILED verdict.
module check_case_scheduler #(
  parameter int NUM_CASES = 8,
  parameter int TIMEOUT   = 16,
  parameter int IDX_W     = 5
) (
  input logic                    clk,
  input logic                    rst,
  check_case_scheduler_if.slave  io_bus
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t               r_state, w_nextState;
  logic [NUM_CASES-1:0] r_enMask, w_enMask;
  logic [NUM_CASES-1:0] r_caseStart, w_caseStart;
  logic [NUM_CASES-1:0] r_failMask, w_failMask;
  logic [NUM_CASES-1:0] r_timeoutMask, w_timeoutMask;
  logic [IDX_W-1:0]     r_curCase, w_curCase;
  logic [CNT_W-1:0]     r_waitCnt, w_waitCnt;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 r_passed, w_passed;
  logic                 r_anyRan, w_anyRan;

  logic [NUM_CASES-1:0] w_curOneHot;
  logic [NUM_CASES-1:0] w_cand;
  logic [IDX_W-1:0]     w_foundIdx;
  logic                 w_found;
  logic                 w_curDone;
  logic                 w_curPass;
  logic                 w_timeout;
  logic                 w_lastCase;

  // Candidates are enabled slots at or above the current index, so one SCAN skips any run of disabled slots.
  assign w_curOneHot = NUM_CASES'(1) << r_curCase;
  assign w_cand      = r_enMask & ~(w_curOneHot - NUM_CASES'(1));
  assign w_curDone   = |(io_bus.case_done & w_curOneHot);
  assign w_curPass   = |(io_bus.case_pass & w_curOneHot);
  assign w_timeout   = (r_waitCnt == CNT_W'(TIMEOUT - 1));
  assign w_lastCase  = (r_curCase == IDX_W'(NUM_CASES - 1));

  always_comb begin
    w_found    = 1'b0;
    w_foundIdx = '0;
    for (int i = NUM_CASES - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_found    = 1'b1;
        w_foundIdx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_enMask      <= '0;
      r_caseStart   <= '0;
      r_failMask    <= '0;
      r_timeoutMask <= '0;
      r_curCase     <= '0;
      r_waitCnt     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_passed      <= 1'b0;
      r_anyRan      <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_enMask      <= w_enMask;
      r_caseStart   <= w_caseStart;
      r_failMask    <= w_failMask;
      r_timeoutMask <= w_timeoutMask;
      r_curCase     <= w_curCase;
      r_waitCnt     <= w_waitCnt;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_passed      <= w_passed;
      r_anyRan      <= w_anyRan;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (io_bus.start) w_nextState = S_SCAN;
      S_SCAN:         w_nextState = w_found ? S_LAUNCH : S_DONE;
      S_LAUNCH:       w_nextState = S_WAIT;
      S_WAIT:         if (w_curDone || w_timeout) w_nextState = S_NEXT;
      S_NEXT:         w_nextState = w_lastCase ? S_DONE : S_SCAN;
      default:        w_nextState = S_IDLE;
    endcase
  end

  // Outputs are registered, so the launch pulse decoded in LAUNCH is seen during the first WAIT cycle.
  always_comb begin
    w_enMask      = r_enMask;
    w_caseStart   = '0;
    w_failMask    = r_failMask;
    w_timeoutMask = r_timeoutMask;
    w_curCase     = r_curCase;
    w_waitCnt     = r_waitCnt;
    w_busy        = r_busy;
    w_done        = r_done;
    w_passed      = r_passed;
    w_anyRan      = r_anyRan;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (io_bus.start) begin
          w_enMask      = io_bus.enable_mask;
          w_failMask    = '0;
          w_timeoutMask = '0;
          w_curCase     = '0;
          w_busy        = 1'b1;
          w_done        = 1'b0;
          w_passed      = 1'b0;
          w_anyRan      = 1'b0;
        end
      end
      S_SCAN: begin
        if (w_found) w_curCase = w_foundIdx;
      end
      S_LAUNCH: begin
        w_caseStart = w_curOneHot;
        w_waitCnt   = '0;
        w_anyRan    = 1'b1;
      end
      S_WAIT: begin
        if (w_curDone) begin
          if (!w_curPass) w_failMask = r_failMask | w_curOneHot;
        end else if (w_timeout) begin
          w_failMask    = r_failMask | w_curOneHot;
          w_timeoutMask = r_timeoutMask | w_curOneHot;
        end else begin
          w_waitCnt = r_waitCnt + CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (!w_lastCase) w_curCase = r_curCase + IDX_W'(1);
      end
      default: ;
    endcase
    if ((w_nextState == S_DONE) && (r_state != S_DONE)) begin
      w_busy    = 1'b0;
      w_done    = 1'b1;
      w_curCase = '0;
      w_passed  = r_anyRan && (r_failMask == '0);
    end
  end

  assign io_bus.case_start   = r_caseStart;
  assign io_bus.busy         = r_busy;
  assign io_bus.cur_case     = r_curCase;
  assign io_bus.fail_mask    = r_failMask;
  assign io_bus.timeout_mask = r_timeoutMask;
  assign io_bus.done         = r_done;
  assign io_bus.passed       = r_passed;
endmodule
